// File: rtl/alu_ctrl_decode.sv
// ID/EX ALU control decoder for a MIPS subset: decodes instr into a registered ALU control word.
// Optional macro DECODE_ILLEGAL_EN flags undecodable instructions instead of executing them as ADD.
module alu_ctrl_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  output logic [5:0]  alu_fun,
  output logic        sign,
  output logic        src_a,
  output logic        src_b,
  output logic        ext_sign,
  output logic        lui,
  output logic        valid_out,
  output logic        illegal
);

  localparam int unsigned FUN_W = 6;

  localparam logic [FUN_W-1:0] FUN_ADD = 6'b000000;
  localparam logic [FUN_W-1:0] FUN_SUB = 6'b000001;
  localparam logic [FUN_W-1:0] FUN_AND = 6'b011000;
  localparam logic [FUN_W-1:0] FUN_OR  = 6'b011110;
  localparam logic [FUN_W-1:0] FUN_XOR = 6'b010110;
  localparam logic [FUN_W-1:0] FUN_NOR = 6'b010001;
  localparam logic [FUN_W-1:0] FUN_SLL = 6'b100000;
  localparam logic [FUN_W-1:0] FUN_SRL = 6'b100001;
  localparam logic [FUN_W-1:0] FUN_SRA = 6'b100011;
  localparam logic [FUN_W-1:0] FUN_EQ  = 6'b110011;
  localparam logic [FUN_W-1:0] FUN_NEQ = 6'b110001;
  localparam logic [FUN_W-1:0] FUN_LT  = 6'b110101;
  localparam logic [FUN_W-1:0] FUN_LEZ = 6'b111101;
  localparam logic [FUN_W-1:0] FUN_LTZ = 6'b111011;
  localparam logic [FUN_W-1:0] FUN_GTZ = 6'b111111;

  typedef struct packed {
    logic [FUN_W-1:0] alu_fun;
    logic             sign;
    logic             src_a;
    logic             src_b;
    logic             ext_sign;
    logic             lui;
    logic             valid;
    logic             illegal;
  } ctrl_t;

  ctrl_t      dec_c;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic       known_c;
  logic [5:0] op_c;
  logic [5:0] funct_c;
  logic [4:0] rt_c;
  logic       unused_instr_c;

  assign op_c           = instr[31:26];
  assign funct_c        = instr[5:0];
  assign rt_c           = instr[20:16];
  assign unused_instr_c = ^{instr[25:21], instr[15:6]};

  // Instruction decode into a control word; known_c drops for anything unsupported.
  always_comb begin
    dec_c   = '0;
    known_c = 1'b1;
    case (op_c)
      6'h00: begin
        case (funct_c)
          6'h20: begin dec_c.alu_fun = FUN_ADD; dec_c.sign = 1'b1; end
          6'h21: dec_c.alu_fun = FUN_ADD;
          6'h22: begin dec_c.alu_fun = FUN_SUB; dec_c.sign = 1'b1; end
          6'h23: dec_c.alu_fun = FUN_SUB;
          6'h24: dec_c.alu_fun = FUN_AND;
          6'h25: dec_c.alu_fun = FUN_OR;
          6'h26: dec_c.alu_fun = FUN_XOR;
          6'h27: dec_c.alu_fun = FUN_NOR;
          6'h2A: begin dec_c.alu_fun = FUN_LT; dec_c.sign = 1'b1; end
          6'h2B: dec_c.alu_fun = FUN_LT;
          6'h00: begin dec_c.alu_fun = FUN_SLL; dec_c.src_a = 1'b1; end
          6'h02: begin dec_c.alu_fun = FUN_SRL; dec_c.src_a = 1'b1; end
          6'h03: begin dec_c.alu_fun = FUN_SRA; dec_c.src_a = 1'b1; end
          6'h04: dec_c.alu_fun = FUN_SLL;
          6'h06: dec_c.alu_fun = FUN_SRL;
          6'h07: dec_c.alu_fun = FUN_SRA;
          6'h08, 6'h09: dec_c.alu_fun = FUN_ADD;
          default: known_c = 1'b0;
        endcase
      end
      6'h08: begin dec_c.alu_fun = FUN_ADD; dec_c.sign = 1'b1; dec_c.ext_sign = 1'b1; dec_c.src_b = 1'b1; end
      6'h09: begin dec_c.alu_fun = FUN_ADD; dec_c.ext_sign = 1'b1; dec_c.src_b = 1'b1; end
      6'h0A: begin dec_c.alu_fun = FUN_LT; dec_c.sign = 1'b1; dec_c.ext_sign = 1'b1; dec_c.src_b = 1'b1; end
      6'h0B: begin dec_c.alu_fun = FUN_LT; dec_c.ext_sign = 1'b1; dec_c.src_b = 1'b1; end
      6'h0C: begin dec_c.alu_fun = FUN_AND; dec_c.src_b = 1'b1; end
      6'h0D: begin dec_c.alu_fun = FUN_OR; dec_c.src_b = 1'b1; end
      6'h0E: begin dec_c.alu_fun = FUN_XOR; dec_c.src_b = 1'b1; end
      6'h0F: begin dec_c.alu_fun = FUN_OR; dec_c.src_b = 1'b1; dec_c.lui = 1'b1; end
      6'h23, 6'h2B: begin dec_c.alu_fun = FUN_ADD; dec_c.ext_sign = 1'b1; dec_c.src_b = 1'b1; end
      6'h04: begin dec_c.alu_fun = FUN_EQ; dec_c.sign = 1'b1; end
      6'h05: begin dec_c.alu_fun = FUN_NEQ; dec_c.sign = 1'b1; end
      6'h06: begin dec_c.alu_fun = FUN_LEZ; dec_c.sign = 1'b1; end
      6'h07: begin dec_c.alu_fun = FUN_GTZ; dec_c.sign = 1'b1; end
      6'h01: begin
        if (rt_c == 5'd0) begin
          dec_c.alu_fun = FUN_LTZ;
          dec_c.sign    = 1'b1;
        end else begin
          known_c = 1'b0;
        end
      end
      6'h02, 6'h03: dec_c.alu_fun = FUN_ADD;
      default: known_c = 1'b0;
    endcase
  end

  // Pipeline register update: flush beats stall beats load; reset handled in the flop.
  always_comb begin
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (!stall) begin
      ctrl_d = '0;
      if (valid_in) begin
        if (known_c) begin
          ctrl_d       = dec_c;
          ctrl_d.valid = 1'b1;
        end else begin
`ifdef DECODE_ILLEGAL_EN
          ctrl_d.illegal = 1'b1;
`else
          ctrl_d.valid   = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign alu_fun   = ctrl_q.alu_fun;
  assign sign      = ctrl_q.sign;
  assign src_a     = ctrl_q.src_a;
  assign src_b     = ctrl_q.src_b;
  assign ext_sign  = ctrl_q.ext_sign;
  assign lui       = ctrl_q.lui;
  assign valid_out = ctrl_q.valid;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Scoreboard bench for alu_ctrl_decode: mnemonic-level reference model, directed and random stimulus.
// Honours DECODE_ILLEGAL_EN when compiled with the same define as the RTL.
module tb_alu_ctrl_decode;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall, flush;
  logic [31:0] instr;
  logic [5:0]  alu_fun;
  logic        sign, src_a, src_b, ext_sign, lui, valid_out, illegal;

  alu_ctrl_decode dut (
    .clk(clk), .reset(reset), .instr(instr), .valid_in(valid_in), .stall(stall), .flush(flush),
    .alu_fun(alu_fun), .sign(sign), .src_a(src_a), .src_b(src_b), .ext_sign(ext_sign),
    .lui(lui), .valid_out(valid_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] fun;
    logic s, a, b, e, l, v, il;
  } exp_t;

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLL, M_SRL, M_SRA,
                M_EQ, M_NEQ, M_LT, M_LEZ, M_LTZ, M_GTZ, M_BAD} mn_t;

  exp_t q_sb[$];
  exp_t model_q;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [5:0] fun_of(input mn_t m);
    case (m)
      M_SUB: return 6'b000001;
      M_AND: return 6'b011000;
      M_OR:  return 6'b011110;
      M_XOR: return 6'b010110;
      M_NOR: return 6'b010001;
      M_SLL: return 6'b100000;
      M_SRL: return 6'b100001;
      M_SRA: return 6'b100011;
      M_EQ:  return 6'b110011;
      M_NEQ: return 6'b110001;
      M_LT:  return 6'b110101;
      M_LEZ: return 6'b111101;
      M_LTZ: return 6'b111011;
      M_GTZ: return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  // Reference: classify instruction into mnemonic plus flag set, then build the word.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t r;
    mn_t m;
    int op, fn, rt;
    op = int'(w[31:26]); fn = int'(w[5:0]); rt = int'(w[20:16]);
    r = '0; m = M_BAD;
    if (op == 0) begin
      if (fn >= 'h20 && fn <= 'h23) begin
        m = (fn < 'h22) ? M_ADD : M_SUB; r.s = (fn % 2 == 0);
      end else if (fn == 'h24) m = M_AND;
      else if (fn == 'h25) m = M_OR;
      else if (fn == 'h26) m = M_XOR;
      else if (fn == 'h27) m = M_NOR;
      else if (fn == 'h2A || fn == 'h2B) begin m = M_LT; r.s = (fn == 'h2A); end
      else if (fn == 'h00 || fn == 'h04) begin m = M_SLL; r.a = (fn < 4); end
      else if (fn == 'h02 || fn == 'h06) begin m = M_SRL; r.a = (fn < 4); end
      else if (fn == 'h03 || fn == 'h07) begin m = M_SRA; r.a = (fn < 4); end
      else if (fn == 'h08 || fn == 'h09) m = M_ADD;
    end else if (op >= 'h08 && op <= 'h0F || op == 'h23 || op == 'h2B) begin
      r.b = 1;
      case (op)
        'h08: begin m = M_ADD; r.s = 1; r.e = 1; end
        'h09: begin m = M_ADD; r.e = 1; end
        'h0A: begin m = M_LT;  r.s = 1; r.e = 1; end
        'h0B: begin m = M_LT;  r.e = 1; end
        'h0C: m = M_AND;
        'h0D: m = M_OR;
        'h0E: m = M_XOR;
        'h0F: begin m = M_OR; r.l = 1; end
        default: begin m = M_ADD; r.e = 1; end
      endcase
    end else if (op >= 'h04 && op <= 'h07 || (op == 1 && rt == 0)) begin
      r.s = 1;
      m = (op == 4) ? M_EQ : (op == 5) ? M_NEQ : (op == 6) ? M_LEZ : (op == 7) ? M_GTZ : M_LTZ;
    end else if (op == 2 || op == 3) begin
      m = M_ADD;
    end
    if (m == M_BAD) begin
      r = '0;
`ifdef DECODE_ILLEGAL_EN
      r.il = 1;
`else
      r.v = 1;
`endif
    end else begin
      r.fun = fun_of(m);
      r.v = 1;
    end
    return r;
  endfunction

  task automatic step(input logic [31:0] i, input logic v, input logic st, input logic fl, input logic rs);
    @(negedge clk);
    instr = i; valid_in = v; stall = st; flush = fl; reset = rs;
    if (rs || fl)   model_q = '0;
    else if (!st)   model_q = v ? ref_decode(i) : exp_t'(0);
    q_sb.push_back(model_q);
  endtask

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t dut_word();
    return {alu_fun, sign, src_a, src_b, ext_sign, lui, valid_out, illegal};
  endfunction

  // Monitor: every clock the DUT presents a new control word; compare against oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q_sb.size() > 0) begin
      exp_t e;
      e = q_sb.pop_front();
      chk("scoreboard", dut_word(), e);
    end
  end

  initial begin
    logic [31:0] w;
    int ops[19] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h23};
    int fns[18] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 0, 2, 3, 4, 6, 7, 8, 9};
    instr = '0; valid_in = 0; stall = 0; flush = 0; reset = 1;
    model_q = '0;

    step(32'h0, 0, 0, 0, 1);
    step(32'h0, 1, 1, 1, 1);
    // add
    step(32'h012A4020, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("add_word", dut_word(), {6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    // sll then sltiu
    step(32'h00094080, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("sll_fun_srca", {7'd0, alu_fun, src_a}, {7'd0, 6'b100000, 1'b1});
    step(32'h2D09FFFF, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("sltiu_word", dut_word(), {6'b110101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    // beq held across a stall with changing instr, then stall+flush
    step(32'h11090003, 1, 0, 0, 0);
    step(32'h012A4020, 1, 1, 0, 0);
    step(32'h3C011234, 1, 1, 0, 0);
    step(32'hFC000000, 1, 1, 0, 0);
    @(posedge clk); #2;
    chk("beq_held", {7'd0, alu_fun}, {7'd0, 6'b110011});
    step(32'h012A4020, 1, 1, 1, 0);
    @(posedge clk); #2;
    chk("flush_bubble", dut_word(), 13'd0);
    // lui then bubble
    step(32'h3C011234, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("lui_word", dut_word(), {6'b011110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    step(32'h3C011234, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("invalid_in", {12'd0, valid_out}, 13'd0);
    // undecodable opcode
    step(32'hFC000000, 1, 0, 0, 0);
    @(posedge clk); #2;
`ifdef DECODE_ILLEGAL_EN
    chk("illegal_op", dut_word(), {6'b000000, 5'b00000, 1'b0, 1'b1});
`else
    chk("illegal_op", dut_word(), {6'b000000, 5'b00000, 1'b1, 1'b0});
`endif
    // reset during a stall holding a valid instruction
    step(32'h11090003, 1, 0, 0, 0);
    step(32'h11090003, 1, 1, 0, 0);
    step(32'h11090003, 1, 1, 0, 1);
    @(posedge clk); #2;
    chk("reset_in_stall", dut_word(), 13'd0);
    step(32'h00094082, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("load_after_reset", {7'd0, alu_fun}, {7'd0, 6'b100001});

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic st, fl, rs, v;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:26] = 6'(ops[$urandom_range(0, 18)]);
      if ($urandom_range(0, 3) != 0) w[5:0] = 6'(fns[$urandom_range(0, 17)]);
      if ($urandom_range(0, 1) == 1) w[20:16] = 5'd0;
      v  = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 29) == 0);
      step(w, v, st, fl, rs);
    end

    begin
      int budget = 20;
      while (q_sb.size() > 0 && budget > 0) begin
        @(posedge clk); #2;
        budget--;
      end
      checks++;
      if (q_sb.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d required=0", q_sb.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decode.md
ALU_CTRL_DECODE -- requirements
Module: alu_ctrl_decode

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- instr  input  32  MIPS instruction word from IF/ID
- valid_in  input  1  instr is a real instruction, not a bubble
- stall  input  1  hold the ID/EX control register
- flush  input  1  replace the ID/EX control register with a bubble
- alu_fun  output  6  registered ALUFun for the ALU
- sign  output  1  registered signed-compare flag for the ALU
- src_a  output  1  0 selects rs; 1 selects zero-extended instr[10:6] (shamt)
- src_b  output  1  0 selects rt; 1 selects the extended immediate
- ext_sign  output  1  1 sign-extends imm16; 0 zero-extends it
- lui  output  1  immediate is imm16<<16
- valid_out  output  1  registered contents are a real instruction
- illegal  output  1  registered opcode/funct was undecodable

Function
REQ-002 All outputs SHALL be registered; there SHALL be one cycle of latency from instr/valid_in to the outputs.
REQ-003 Per-edge priority SHALL be: reset, then flush, then stall, then load.
REQ-004 A flush SHALL load a bubble: valid_out=0, illegal=0, alu_fun=000000, and all other control outputs 0; flush wins over a simultaneous stall.
REQ-005 A stall without flush SHALL hold every output unchanged, for any number of cycles.
REQ-006 A load with valid_in=0 SHALL load a bubble.
REQ-007 ALUFun codes SHALL be: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-008 R-type decoding (opcode 0) SHALL be by funct:
- 0x20 ADD s=1; 0x21 ADD s=0; 0x22 SUB s=1; 0x23 SUB s=0
- 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR
- 0x2A LT s=1; 0x2B LT s=0
- 0x00/0x02/0x03 SLL/SRL/SRA with src_a=1
- 0x04/0x06/0x07 SLL/SRL/SRA with src_a=0
- 0x08, 0x09 (jr, jalr) ADD
REQ-009 I-type decoding SHALL set src_b=1 and be by opcode:
- 0x08 ADD s=1 ext=1; 0x09 ADD ext=1
- 0x0A LT s=1 ext=1; 0x0B LT s=0 ext=1
- 0x0C AND ext=0; 0x0D OR ext=0; 0x0E XOR ext=0
- 0x0F OR with lui=1
- 0x23, 0x2B ADD ext=1
REQ-010 Branch decoding SHALL set src_b=0 and sign=1:
- 0x04 EQ; 0x05 NEQ; 0x06 LEZ; 0x07 GTZ
- 0x01 with rt=0 LTZ
REQ-011 Opcodes 0x02 and 0x03 (j, jal) SHALL decode as legal ADD with all selects 0.
REQ-012 Any control output not listed for an instruction SHALL be 0.
REQ-013 Any other opcode/funct SHALL be undecodable and handled per REQ-016/REQ-017.

Reset
REQ-014 While reset=1 at a clock edge, all outputs SHALL be loaded with the bubble values of REQ-004, regardless of stall or flush.
REQ-015 When reset is asserted mid-stall, the held instruction SHALL be discarded; the first load after reset is released is a normal load.

Configuration
REQ-016 With the macro DECODE_ILLEGAL_EN defined, an undecodable valid instruction SHALL load illegal=1, valid_out=0 and alu_fun=000000.
REQ-017 Without DECODE_ILLEGAL_EN, illegal SHALL be tied 0, and an undecodable valid instruction SHALL load valid_out=1, ADD, and all selects 0.

Verification
REQ-018 Reset, then instr=0x012A4020 (add), valid_in=1 -> next cycle alu_fun=000000, sign=1, src_a=0, src_b=0, valid_out=1.
REQ-019 instr=0x00094080 (sll $t0,$t1,2) -> alu_fun=100000, src_a=1; then instr=0x2D09FFFF (sltiu) -> alu_fun=110101, sign=0, src_b=1, ext_sign=1.
REQ-020 Load beq 0x11090003, then stall=1 for 3 cycles with instr changing -> outputs held at alu_fun=110011 throughout; stall=1 and flush=1 together -> bubble on the next cycle.
REQ-021 instr=0x3C011234 (lui) -> alu_fun=011110, lui=1, src_b=1; then valid_in=0 -> valid_out=0.
REQ-022 instr=0xFC000000:
- with DECODE_ILLEGAL_EN -> illegal=1, valid_out=0
- without it -> illegal=0, valid_out=1, alu_fun=000000
REQ-023 Assert reset during a stall holding a valid instruction -> outputs are bubble on the next cycle; release reset -> the next load works.
